// File: rtl/psg_register_file.sv
// Write-side bus interface and control register bank of an SN76489-compatible PSG.
// Decodes LATCH/DATA bytes strobed by an asynchronous we_n and holds tone, attenuation and noise settings.
module psg_register_file #(
   parameter int PERIOD_BITS  = 10,
   parameter int ATTN_BITS    = 4,
   parameter int SYNC_STAGES  = 2,
   parameter int READY_CYCLES = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             data,
   input  logic                   we_n,
   output logic                   ready,
   output logic [PERIOD_BITS-1:0] tone_period0,
   output logic [PERIOD_BITS-1:0] tone_period1,
   output logic [PERIOD_BITS-1:0] tone_period2,
   output logic [ATTN_BITS-1:0]   attn0,
   output logic [ATTN_BITS-1:0]   attn1,
   output logic [ATTN_BITS-1:0]   attn2,
   output logic [ATTN_BITS-1:0]   attn3,
   output logic [2:0]             noise_control,
   output logic                   restart_noise
);

   localparam int CNT_BITS = $clog2(READY_CYCLES + 1);
   localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(READY_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_chain;
   logic [SYNC_STAGES-1:0] flush;
   logic                   we_prev;
   logic                   strobe_fall;
   logic                   accept;
   logic [CNT_BITS-1:0]    busy_cnt;
   logic [1:0]             tgt_chan;
   logic                   tgt_attn;
   logic [PERIOD_BITS-1:0] period [3];
   logic [ATTN_BITS-1:0]   attn [4];

   // flush marks when the chain holds real we_n samples rather than reset 1s, so a
   // strobe already held low across reset release never counts as a fresh edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_chain <= '1;
         flush      <= '0;
         we_prev    <= 1'b1;
      end else begin
         sync_chain <= {sync_chain[SYNC_STAGES-2:0], we_n};
         flush      <= {flush[SYNC_STAGES-2:0], 1'b1};
         we_prev    <= flush[SYNC_STAGES-1] & sync_chain[SYNC_STAGES-1];
      end
   end

   assign strobe_fall = we_prev & ~sync_chain[SYNC_STAGES-1];
   assign accept      = strobe_fall & ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready    <= 1'b1;
         busy_cnt <= '0;
      end else if (accept) begin
         ready    <= 1'b0;
         busy_cnt <= CNT_LOAD;
      end else if (!ready) begin
         if (busy_cnt == '0) begin
            ready <= 1'b1;
         end else begin
            busy_cnt <= busy_cnt - 1'b1;
         end
      end
   end

   // DATA bytes go to the target remembered from the most recent LATCH byte
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tgt_chan      <= 2'd0;
         tgt_attn      <= 1'b0;
         noise_control <= 3'd0;
         restart_noise <= 1'b0;
         for (int i = 0; i < 3; i++) period[i] <= '0;
         for (int i = 0; i < 4; i++) attn[i] <= '1;
      end else begin
         restart_noise <= 1'b0;
         if (accept) begin
            if (data[7]) begin
               tgt_chan <= data[6:5];
               tgt_attn <= data[4];
               if (data[4]) begin
                  attn[data[6:5]] <= data[ATTN_BITS-1:0];
               end else if (data[6:5] == 2'd3) begin
                  noise_control <= data[2:0];
                  restart_noise <= 1'b1;
               end else begin
                  for (int i = 0; i < 3; i++)
                     if (data[6:5] == i[1:0]) period[i][3:0] <= data[3:0];
               end
            end else begin
               if (tgt_attn) begin
                  attn[tgt_chan] <= data[ATTN_BITS-1:0];
               end else if (tgt_chan == 2'd3) begin
                  noise_control <= data[2:0];
                  restart_noise <= 1'b1;
               end else begin
                  for (int i = 0; i < 3; i++)
                     if (tgt_chan == i[1:0]) period[i][PERIOD_BITS-1:4] <= data[PERIOD_BITS-5:0];
               end
            end
         end
      end
   end

   assign tone_period0 = period[0];
   assign tone_period1 = period[1];
   assign tone_period2 = period[2];
   assign attn0        = attn[0];
   assign attn1        = attn[1];
   assign attn2        = attn[2];
   assign attn3        = attn[3];

endmodule

// File: tb/tb_psg_register_file.sv
// Directed self-checking bench for psg_register_file: byte decode, strobe timing,
// busy/ready window, dropped writes and asynchronous reset.
module tb_psg_register_file;

   logic       clk;
   logic       rst_n;
   logic [7:0] data;
   logic       we_n;
   logic       ready;
   logic [9:0] tone_period0, tone_period1, tone_period2;
   logic [3:0] attn0, attn1, attn2, attn3;
   logic [2:0] noise_control;
   logic       restart_noise;

   int checks = 0;
   int errors = 0;

   psg_register_file dut (
      .clk(clk), .rst_n(rst_n), .data(data), .we_n(we_n), .ready(ready),
      .tone_period0(tone_period0), .tone_period1(tone_period1), .tone_period2(tone_period2),
      .attn0(attn0), .attn1(attn1), .attn2(attn2), .attn3(attn3),
      .noise_control(noise_control), .restart_noise(restart_noise)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drops we_n and returns just after the third clock edge, where the write lands
   task automatic applyStimulus(input logic [7:0] b);
      data = b;
      we_n = 1'b0;
      repeat (3) tick();
   endtask

   // Releases the strobe and measures how long ready stayed low since the write edge
   task automatic finishWrite(input string tag);
      int n;
      tick();
      n = 1;
      checkOutput({tag, "_pulse_end"}, 32'(restart_noise), 0);
      we_n = 1'b1;
      while (!ready && n < 200) begin
         tick();
         n++;
      end
      checkOutput({tag, "_ready_low"}, n, 32);
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      we_n  = 1'b1;
      data  = 8'h00;
      repeat (2) tick();

      checkOutput("rst_tp0", 32'(tone_period0), 0);
      checkOutput("rst_tp1", 32'(tone_period1), 0);
      checkOutput("rst_tp2", 32'(tone_period2), 0);
      checkOutput("rst_attn0", 32'(attn0), 4'hF);
      checkOutput("rst_attn1", 32'(attn1), 4'hF);
      checkOutput("rst_attn2", 32'(attn2), 4'hF);
      checkOutput("rst_attn3", 32'(attn3), 4'hF);
      checkOutput("rst_noise", 32'(noise_control), 0);
      checkOutput("rst_ready", 32'(ready), 1);
      checkOutput("rst_restart", 32'(restart_noise), 0);
      rst_n = 1'b1;
      repeat (5) tick();

      // Tone latch with explicit edge-by-edge timing of the write event
      data = 8'h8E;
      we_n = 1'b0;
      repeat (2) tick();
      checkOutput("t2_pre_w_tp0", 32'(tone_period0), 0);
      checkOutput("t2_pre_w_ready", 32'(ready), 1);
      tick();
      checkOutput("t2_latch_tp0", 32'(tone_period0), 10'h00E);
      checkOutput("t2_latch_ready", 32'(ready), 0);
      finishWrite("t2_latch");
      applyStimulus(8'h0F);
      checkOutput("t2_data_tp0", 32'(tone_period0), 10'h0FE);
      finishWrite("t2_data");

      applyStimulus(8'hE5);
      checkOutput("t3_noise_latch", 32'(noise_control), 3'b101);
      checkOutput("t3_pulse1", 32'(restart_noise), 1);
      finishWrite("t3_latch");
      applyStimulus(8'h02);
      checkOutput("t3_noise_data", 32'(noise_control), 3'b010);
      checkOutput("t3_pulse2", 32'(restart_noise), 1);
      finishWrite("t3_data");

      applyStimulus(8'hBF);
      checkOutput("t4_attn1_latch", 32'(attn1), 4'hF);
      checkOutput("t4_no_pulse", 32'(restart_noise), 0);
      finishWrite("t4_latch");
      applyStimulus(8'h03);
      checkOutput("t4_attn1_data", 32'(attn1), 4'h3);
      checkOutput("t4_attn0", 32'(attn0), 4'hF);
      checkOutput("t4_attn2", 32'(attn2), 4'hF);
      checkOutput("t4_attn3", 32'(attn3), 4'hF);
      checkOutput("t4_tp0", 32'(tone_period0), 10'h0FE);
      checkOutput("t4_noise", 32'(noise_control), 3'b010);
      finishWrite("t4_data");

      // A write attempted inside the busy window must be dropped without touching ready
      applyStimulus(8'h85);
      checkOutput("t5_tp0", 32'(tone_period0), 10'h0F5);
      tick();
      we_n = 1'b1;
      repeat (3) tick();
      data = 8'h9A;
      we_n = 1'b0;
      repeat (3) tick();
      n = 7;
      checkOutput("t5_drop_attn0", 32'(attn0), 4'hF);
      checkOutput("t5_drop_tp0", 32'(tone_period0), 10'h0F5);
      we_n = 1'b1;
      while (!ready && n < 200) begin
         tick();
         n++;
      end
      checkOutput("t5_ready_low", n, 32);
      repeat (3) tick();

      applyStimulus(8'h91);
      checkOutput("t5_hold_attn0", 32'(attn0), 4'h1);
      data = 8'h97;
      repeat (97) tick();
      checkOutput("t5_hold_once_attn0", 32'(attn0), 4'h1);
      checkOutput("t5_hold_ready", 32'(ready), 1);
      we_n = 1'b1;
      repeat (3) tick();

      // Reset in the middle of a busy window with the strobe still held low
      applyStimulus(8'hA4);
      checkOutput("t6_tp1", 32'(tone_period1), 10'h004);
      checkOutput("t6_busy", 32'(ready), 0);
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_ready", 32'(ready), 1);
      checkOutput("t6_rst_tp0", 32'(tone_period0), 0);
      checkOutput("t6_rst_tp1", 32'(tone_period1), 0);
      checkOutput("t6_rst_attn0", 32'(attn0), 4'hF);
      checkOutput("t6_rst_attn1", 32'(attn1), 4'hF);
      checkOutput("t6_rst_noise", 32'(noise_control), 0);
      repeat (2) tick();
      data = 8'h9B;
      rst_n = 1'b1;
      repeat (20) tick();
      checkOutput("t6_post_attn0", 32'(attn0), 4'hF);
      checkOutput("t6_post_ready", 32'(ready), 1);
      we_n = 1'b1;
      repeat (5) tick();
      applyStimulus(8'h9B);
      checkOutput("t6_alive_attn0", 32'(attn0), 4'hB);
      finishWrite("t6_alive");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
